// File: rtl/rrd_sched_pkg.sv
// Shared types and constants for the register-read port scheduler.
package rrd_sched_pkg;

   localparam logic [1:0] RT_FIX     = 2'd0;
   localparam int         STARVE_W   = 3;
   localparam int         PREG_W_DEF = 7;
   localparam int         BR_W_DEF   = 16;
   localparam int         PORTS_DEF  = 4;
   localparam int         PIDX_W     = $clog2(PORTS_DEF);

   typedef logic [PIDX_W-1:0] port_idx_t;

   typedef struct packed {
      logic                  valid;
      logic [PREG_W_DEF-1:0] prs1;
      logic [PREG_W_DEF-1:0] prs2;
      logic                  rs1_used;
      logic                  rs2_used;
      logic [BR_W_DEF-1:0]   br_mask;
   } rrd_req_t;

   // Number of integer read ports a uop occupies.
   function automatic logic [1:0] need_of(input logic rs1_used, input logic rs2_used);
      return {1'b0, rs1_used} + {1'b0, rs2_used};
   endfunction

endpackage

// File: rtl/rrd_port_alloc.sv
// Combinational priority allocator: urgent slots first, then the rest, each
// pass in ascending slot order, ports handed out lowest index first.
module rrd_port_alloc
   import rrd_sched_pkg::*;
#(
   parameter int NUM_SLOTS = 3,
   parameter int NUM_PORTS = 4,
   parameter int SIDX_W    = 2
)(
   input  logic [NUM_SLOTS-1:0]        active_i,
   input  logic [NUM_SLOTS-1:0]        urgent_i,
   input  logic [NUM_SLOTS*2-1:0]      need_i,
   input  logic [NUM_SLOTS-1:0]        rs1_used_i,
   output logic [NUM_SLOTS-1:0]        gnt_o,
   output logic [NUM_SLOTS*PIDX_W-1:0] rs1_port_o,
   output logic [NUM_SLOTS*PIDX_W-1:0] rs2_port_o,
   output logic [NUM_PORTS-1:0]        port_used_o,
   output logic [NUM_PORTS*SIDX_W-1:0] port_slot_o,
   output logic [NUM_PORTS-1:0]        port_rs2_o
);

   int nxt;
   int nd;

   // NOTE: every output gets a default first so no path leaves a latch.
   always_comb begin
      gnt_o       = '0;
      rs1_port_o  = '0;
      rs2_port_o  = '0;
      port_used_o = '0;
      port_slot_o = '0;
      port_rs2_o  = '0;
      nxt         = 0;
      nd          = 0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            nd = int'(need_i[s*2 +: 2]);
            if (active_i[s] && (urgent_i[s] == (pass == 0)) && (nxt + nd <= NUM_PORTS)) begin
               gnt_o[s] = 1'b1;
               if (rs1_used_i[s]) begin
                  rs1_port_o[s*PIDX_W +: PIDX_W] = PIDX_W'(nxt);
                  port_used_o[nxt]               = 1'b1;
                  port_slot_o[nxt*SIDX_W +: SIDX_W] = SIDX_W'(s);
                  nxt++;
               end
               if (nd > int'(rs1_used_i[s])) begin
                  rs2_port_o[s*PIDX_W +: PIDX_W] = PIDX_W'(nxt);
                  port_used_o[nxt]               = 1'b1;
                  port_rs2_o[nxt]                = 1'b1;
                  port_slot_o[nxt*SIDX_W +: SIDX_W] = SIDX_W'(s);
                  nxt++;
               end
            end
         end
      end
   end

endmodule

// File: rtl/rrd_read_port_sched.sv
// Register-read stage scheduler sharing integer RF read ports among issue slots.
// Optional RRD_PERF_COUNTERS_EN adds conflict-cycle and urgent-grant counters.
module rrd_read_port_sched
   import rrd_sched_pkg::*;
#(
   parameter int NUM_SLOTS    = 3,
   parameter int NUM_PORTS    = PORTS_DEF,
   parameter int PREG_W       = PREG_W_DEF,
   parameter int BR_W         = BR_W_DEF,
   parameter int STARVE_LIMIT = 3
)(
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_SLOTS-1:0]        req_valid,
   input  logic [NUM_SLOTS*PREG_W-1:0] req_prs1,
   input  logic [NUM_SLOTS*PREG_W-1:0] req_prs2,
   input  logic [NUM_SLOTS-1:0]        req_rs1_used,
   input  logic [NUM_SLOTS-1:0]        req_rs2_used,
   input  logic [NUM_SLOTS*BR_W-1:0]   req_br_mask,
   input  logic [BR_W-1:0]             brupdate_resolve_mask,
   input  logic [BR_W-1:0]             brupdate_mispredict_mask,
   input  logic                        stall,
   output logic [NUM_SLOTS-1:0]        req_gnt,
   output logic [NUM_PORTS*PREG_W-1:0] rf_raddr,
   output logic [NUM_PORTS-1:0]        rf_ren,
   output logic [NUM_SLOTS-1:0]        rrd_valid,
   output logic [NUM_SLOTS*BR_W-1:0]   rrd_br_mask,
   output logic [NUM_SLOTS*PIDX_W-1:0] rrd_rs1_port,
   output logic [NUM_SLOTS*PIDX_W-1:0] rrd_rs2_port
`ifdef RRD_PERF_COUNTERS_EN
   ,
   output logic [31:0]                 perf_conflict_cycles,
   output logic [15:0]                 perf_urgent_grants
`endif
);

   localparam int                  SIDX_W = $clog2(NUM_SLOTS);
   localparam logic [STARVE_W-1:0] LIMIT  = STARVE_W'(STARVE_LIMIT);

   rrd_req_t                    req [NUM_SLOTS];
   logic [STARVE_W-1:0]         starve_q [NUM_SLOTS];
   logic [STARVE_W-1:0]         starve_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]        killed, live, active, urgent, gnt, rs1_used_v;
   logic [NUM_SLOTS*2-1:0]      need;
   logic [NUM_SLOTS*PIDX_W-1:0] alloc_rs1_port, alloc_rs2_port;
   logic [NUM_PORTS-1:0]        port_used, port_rs2;
   logic [NUM_PORTS*SIDX_W-1:0] port_slot;

   logic [NUM_SLOTS-1:0]        rrd_valid_q, rrd_valid_d;
   logic [NUM_SLOTS*BR_W-1:0]   rrd_br_mask_q, rrd_br_mask_d;
   logic [NUM_SLOTS*PIDX_W-1:0] rrd_rs1_port_q, rrd_rs1_port_d;
   logic [NUM_SLOTS*PIDX_W-1:0] rrd_rs2_port_q, rrd_rs2_port_d;

   always_comb begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
         req[s] = '{valid:    req_valid[s],
                    prs1:     req_prs1[s*PREG_W +: PREG_W],
                    prs2:     req_prs2[s*PREG_W +: PREG_W],
                    rs1_used: req_rs1_used[s],
                    rs2_used: req_rs2_used[s],
                    br_mask:  req_br_mask[s*BR_W +: BR_W]};
         killed[s]       = |(req[s].br_mask & brupdate_mispredict_mask);
         live[s]         = req[s].valid & ~killed[s];
         urgent[s]       = (starve_q[s] == LIMIT);
         need[s*2 +: 2]  = need_of(req[s].rs1_used, req[s].rs2_used);
         rs1_used_v[s]   = req[s].rs1_used;
      end
   end

   // Reset and stall both gate the grant path at its source.
   assign active = live & {NUM_SLOTS{reset & ~stall}};

   rrd_port_alloc #(
      .NUM_SLOTS (NUM_SLOTS),
      .NUM_PORTS (NUM_PORTS),
      .SIDX_W    (SIDX_W)
   ) u_alloc (
      .active_i    (active),
      .urgent_i    (urgent),
      .need_i      (need),
      .rs1_used_i  (rs1_used_v),
      .gnt_o       (gnt),
      .rs1_port_o  (alloc_rs1_port),
      .rs2_port_o  (alloc_rs2_port),
      .port_used_o (port_used),
      .port_slot_o (port_slot),
      .port_rs2_o  (port_rs2)
   );

   always_comb begin
      rf_raddr = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (port_used[p]) begin
            rf_raddr[p*PREG_W +: PREG_W] = port_rs2[p] ? req[port_slot[p*SIDX_W +: SIDX_W]].prs2
                                                       : req[port_slot[p*SIDX_W +: SIDX_W]].prs1;
         end
      end
   end

   assign req_gnt = gnt;
   assign rf_ren  = port_used;

   always_comb begin
      rrd_valid_d    = rrd_valid_q;
      rrd_br_mask_d  = rrd_br_mask_q;
      rrd_rs1_port_d = rrd_rs1_port_q;
      rrd_rs2_port_d = rrd_rs2_port_q;
      starve_d       = starve_q;
      if (stall) begin
         // Frozen stage still tracks branch outcomes; mispredict beats resolve.
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (|(rrd_br_mask_q[s*BR_W +: BR_W] & brupdate_mispredict_mask))
               rrd_valid_d[s] = 1'b0;
            rrd_br_mask_d[s*BR_W +: BR_W] = rrd_br_mask_q[s*BR_W +: BR_W] & ~brupdate_resolve_mask;
         end
      end else begin
         rrd_valid_d    = gnt;
         rrd_rs1_port_d = alloc_rs1_port;
         rrd_rs2_port_d = alloc_rs2_port;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            rrd_br_mask_d[s*BR_W +: BR_W] = gnt[s] ? (req[s].br_mask & ~brupdate_resolve_mask) : '0;
            if (!live[s] || gnt[s])
               starve_d[s] = '0;
            else if (starve_q[s] != LIMIT)
               starve_d[s] = STARVE_W'(starve_q[s] + 1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rrd_valid_q    <= '0;
         rrd_br_mask_q  <= '0;
         rrd_rs1_port_q <= '0;
         rrd_rs2_port_q <= '0;
         // NOTE: the counter array is a handful of flops, not a RAM, so it is
         // reset element by element like any other register.
         for (int s = 0; s < NUM_SLOTS; s++) starve_q[s] <= '0;
      end else begin
         rrd_valid_q    <= rrd_valid_d;
         rrd_br_mask_q  <= rrd_br_mask_d;
         rrd_rs1_port_q <= rrd_rs1_port_d;
         rrd_rs2_port_q <= rrd_rs2_port_d;
         for (int s = 0; s < NUM_SLOTS; s++) starve_q[s] <= starve_d[s];
      end
   end

   assign rrd_valid    = rrd_valid_q;
   assign rrd_br_mask  = rrd_br_mask_q;
   assign rrd_rs1_port = rrd_rs1_port_q;
   assign rrd_rs2_port = rrd_rs2_port_q;

`ifdef RRD_PERF_COUNTERS_EN
   logic [31:0] conflict_q;
   logic [15:0] urgent_q;
   logic [16:0] urgent_sum;

   always_comb begin
      urgent_sum = {1'b0, urgent_q};
      for (int s = 0; s < NUM_SLOTS; s++)
         if (gnt[s] && urgent[s]) urgent_sum = urgent_sum + 17'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         conflict_q <= '0;
         urgent_q   <= '0;
      end else begin
         if (!stall && |(live & ~gnt) && conflict_q != '1)
            conflict_q <= conflict_q + 32'd1;
         urgent_q <= urgent_sum[16] ? '1 : urgent_sum[15:0];
      end
   end

   assign perf_conflict_cycles = conflict_q;
   assign perf_urgent_grants   = urgent_q;
`endif

endmodule

// File: tb/tb_rrd_read_port_sched.sv
// Directed scoreboard bench for rrd_read_port_sched: expected RRD entries are
// queued when a request cycle is driven and compared one cycle later.
module tb_rrd_read_port_sched;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  req_valid, req_rs1_used, req_rs2_used;
   logic [20:0] req_prs1, req_prs2;
   logic [47:0] req_br_mask;
   logic [15:0] brupdate_resolve_mask, brupdate_mispredict_mask;
   logic        stall;
   logic [2:0]  req_gnt, rrd_valid;
   logic [27:0] rf_raddr;
   logic [3:0]  rf_ren;
   logic [47:0] rrd_br_mask;
   logic [5:0]  rrd_rs1_port, rrd_rs2_port;
`ifdef RRD_PERF_COUNTERS_EN
   logic [31:0] perf_conflict_cycles;
   logic [15:0] perf_urgent_grants;
`endif

   typedef struct {
      logic [2:0]  v;
      logic [47:0] bm;
      logic [5:0]  p1;
      logic [5:0]  p2;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   localparam logic [27:0] RA_S01  = {7'd21, 7'd20, 7'd11, 7'd10};
   localparam logic [5:0]  P1_S01  = {2'd0, 2'd2, 2'd0};
   localparam logic [5:0]  P2_S01  = {2'd0, 2'd3, 2'd1};

   always #5 clock = ~clock;

   rrd_read_port_sched dut (
      .clock                    (clock),
      .reset                    (reset),
      .req_valid                (req_valid),
      .req_prs1                 (req_prs1),
      .req_prs2                 (req_prs2),
      .req_rs1_used             (req_rs1_used),
      .req_rs2_used             (req_rs2_used),
      .req_br_mask              (req_br_mask),
      .brupdate_resolve_mask    (brupdate_resolve_mask),
      .brupdate_mispredict_mask (brupdate_mispredict_mask),
      .stall                    (stall),
      .req_gnt                  (req_gnt),
      .rf_raddr                 (rf_raddr),
      .rf_ren                   (rf_ren),
      .rrd_valid                (rrd_valid),
      .rrd_br_mask              (rrd_br_mask),
      .rrd_rs1_port             (rrd_rs1_port),
      .rrd_rs2_port             (rrd_rs2_port)
`ifdef RRD_PERF_COUNTERS_EN
      ,
      .perf_conflict_cycles     (perf_conflict_cycles),
      .perf_urgent_grants       (perf_urgent_grants)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Slot s uses prs1 = 10*(s+1), prs2 = 10*(s+1)+1.
   task automatic set_slot(input int s, input logic v, input logic u1, input logic u2,
                           input logic [15:0] bm);
      req_valid[s]              = v;
      req_rs1_used[s]           = u1;
      req_rs2_used[s]           = u2;
      req_prs1[s*7 +: 7]        = 7'(10 * (s + 1));
      req_prs2[s*7 +: 7]        = 7'(10 * (s + 1) + 1);
      req_br_mask[s*16 +: 16]   = bm;
   endtask

   task automatic all_need2();
      for (int s = 0; s < 3; s++) set_slot(s, 1'b1, 1'b1, 1'b1, 16'h0);
   endtask

   // Entered at posedge+1 with inputs driven; leaves at the next posedge+1.
   task automatic cycle(input string tag, input logic [2:0] e_gnt, input logic [3:0] e_ren,
                        input logic [27:0] e_raddr, input logic [2:0] e_v,
                        input logic [47:0] e_bm, input logic [5:0] e_p1, input logic [5:0] e_p2);
      exp_t e;
      sb.push_back('{v: e_v, bm: e_bm, p1: e_p1, p2: e_p2});
      #3;
      check({tag, ".gnt"},   64'(req_gnt),  64'(e_gnt));
      check({tag, ".ren"},   64'(rf_ren),   64'(e_ren));
      check({tag, ".raddr"}, 64'(rf_raddr), 64'(e_raddr));
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({tag, ".rrd_valid"}, 64'(rrd_valid),    64'(e.v));
         check({tag, ".rrd_bm"},    64'(rrd_br_mask),  64'(e.bm));
         check({tag, ".rrd_p1"},    64'(rrd_rs1_port), 64'(e.p1));
         check({tag, ".rrd_p2"},    64'(rrd_rs2_port), 64'(e.p2));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      brupdate_resolve_mask    = '0;
      brupdate_mispredict_mask = '0;
      all_need2();
      #1 reset = 1'b0;
      #2;
      check("reset.gnt",   64'(req_gnt),      64'd0);
      check("reset.ren",   64'(rf_ren),       64'd0);
      check("reset.raddr", 64'(rf_raddr),     64'd0);
      check("reset.valid", 64'(rrd_valid),    64'd0);
      check("reset.bm",    64'(rrd_br_mask),  64'd0);
      check("reset.p1",    64'(rrd_rs1_port), 64'd0);
      @(posedge clock);
      #1 reset = 1'b1;

      // Three slots needing two ports each: slots 0 and 1 fill the pool.
      cycle("t1", 3'b011, 4'hF, RA_S01, 3'b011, 48'h0, P1_S01, P2_S01);
      set_slot(2, 1'b1, 1'b1, 1'b0, 16'h0);
      cycle("t2", 3'b011, 4'hF, RA_S01, 3'b011, 48'h0, P1_S01, P2_S01);
      set_slot(0, 1'b0, 1'b1, 1'b1, 16'h0);
      set_slot(1, 1'b0, 1'b1, 1'b1, 16'h0);
      cycle("t3", 3'b100, 4'h1, {21'd0, 7'd30}, 3'b100, 48'h0, 6'd0, 6'd0);

      // Slot 2 starves three cycles, then becomes urgent and goes first.
      all_need2();
      cycle("t4", 3'b011, 4'hF, RA_S01, 3'b011, 48'h0, P1_S01, P2_S01);
      cycle("t5", 3'b011, 4'hF, RA_S01, 3'b011, 48'h0, P1_S01, P2_S01);
      cycle("t6", 3'b011, 4'hF, RA_S01, 3'b011, 48'h0, P1_S01, P2_S01);
      cycle("t7_urgent", 3'b101, 4'hF, {7'd11, 7'd10, 7'd31, 7'd30}, 3'b101, 48'h0,
            {2'd0, 2'd0, 2'd2}, {2'd1, 2'd0, 2'd3});

      // Killed request takes no ports.
      set_slot(0, 1'b1, 1'b1, 1'b1, 16'h0004);
      set_slot(2, 1'b0, 1'b1, 1'b1, 16'h0);
      brupdate_mispredict_mask = 16'h0004;
      cycle("t8_kill", 3'b010, 4'h3, {14'd0, 7'd21, 7'd20}, 3'b010, 48'h0,
            6'd0, {2'd0, 2'd1, 2'd0});

      brupdate_mispredict_mask = '0;
      set_slot(0, 1'b1, 1'b1, 1'b1, 16'h0008);
      set_slot(1, 1'b1, 1'b1, 1'b1, 16'h0006);
      set_slot(2, 1'b1, 1'b1, 1'b1, 16'h0);
      cycle("t9", 3'b011, 4'hF, RA_S01, 3'b011, {16'h0, 16'h0006, 16'h0008}, P1_S01, P2_S01);

      // Stalled holds: resolve clears bits, mispredict drops entries.
      stall = 1'b1;
      brupdate_resolve_mask = 16'h0002;
      cycle("t10_resolve", 3'b000, 4'h0, 28'd0, 3'b011, {16'h0, 16'h0004, 16'h0008},
            P1_S01, P2_S01);
      brupdate_resolve_mask    = 16'h0004;
      brupdate_mispredict_mask = 16'h0004;
      cycle("t11_both", 3'b000, 4'h0, 28'd0, 3'b001, {16'h0, 16'h0000, 16'h0008},
            P1_S01, P2_S01);
      brupdate_resolve_mask    = 16'h0;
      brupdate_mispredict_mask = 16'h0008;
      cycle("t12_mispred", 3'b000, 4'h0, 28'd0, 3'b000, {16'h0, 16'h0000, 16'h0008},
            P1_S01, P2_S01);

      // Slot 2 counter was 1 before the stall and must still be 1.
      stall = 1'b0;
      brupdate_mispredict_mask = '0;
      all_need2();
      cycle("t13_hold", 3'b011, 4'hF, RA_S01, 3'b011, 48'h0, P1_S01, P2_S01);
      cycle("t14_hold", 3'b011, 4'hF, RA_S01, 3'b011, 48'h0, P1_S01, P2_S01);
      cycle("t15_urgent", 3'b101, 4'hF, {7'd11, 7'd10, 7'd31, 7'd30}, 3'b101, 48'h0,
            {2'd0, 2'd0, 2'd2}, {2'd1, 2'd0, 2'd3});

      // Reset asserted mid-stall clears the stage without a clock edge.
      stall = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("t16_areset.valid", 64'(rrd_valid),    64'd0);
      check("t16_areset.bm",    64'(rrd_br_mask),  64'd0);
      check("t16_areset.p2",    64'(rrd_rs2_port), 64'd0);
      check("t16_areset.gnt",   64'(req_gnt),      64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      stall = 1'b0;

      set_slot(0, 1'b1, 1'b1, 1'b0, 16'h0);
      set_slot(1, 1'b1, 1'b1, 1'b0, 16'h0);
      cycle("t17_mixed", 3'b111, 4'hF, {7'd31, 7'd30, 7'd20, 7'd10}, 3'b111, 48'h0,
            {2'd2, 2'd1, 2'd0}, {2'd3, 2'd0, 2'd0});

      // A need-0 slot is granted even with the pool exhausted.
      all_need2();
      set_slot(2, 1'b1, 1'b0, 1'b0, 16'h0);
      cycle("t18_need0", 3'b111, 4'hF, RA_S01, 3'b111, 48'h0, P1_S01, P2_S01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rrd_read_port_sched.md
Name: rrd_read_port_sched

Overview:
- Register-read-stage scheduler that shares a limited pool of integer register-file read ports among several issue slots.
- Each cycle it grants issue slots whose operand needs fit in the free ports, and drives read-port addresses.
- Granted uops are carried through one pipeline register, together with their port mapping, to the per-slot register-read decode logic.
- Handles branch-kill, backpressure and starvation.

Parameters:
- NUM_SLOTS, 3, issue slots requesting read ports
- NUM_PORTS, 4, physical read ports on the shared register file
- PREG_W, 7, physical register index width
- BR_W, 16, branch mask width
- STARVE_LIMIT, 3, consecutive denials after which a slot becomes urgent (1..7)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_SLOTS  slot s issuing a uop
- req_prs1  in  NUM_SLOTS*PREG_W  rs1 physical index, slot s at [s*PREG_W +: PREG_W]
- req_prs2  in  NUM_SLOTS*PREG_W  rs2 physical index
- req_rs1_used  in  NUM_SLOTS  rs1 is an integer operand (lrs1_rtype == RT_FIX)
- req_rs2_used  in  NUM_SLOTS  rs2 is an integer operand
- req_br_mask  in  NUM_SLOTS*BR_W  branch mask of the requesting uop
- brupdate_resolve_mask  in  BR_W  branches resolved this cycle
- brupdate_mispredict_mask  in  BR_W  branches mispredicted this cycle
- stall  in  1  downstream cannot accept; freeze the stage
- req_gnt  out  NUM_SLOTS  combinational grant back to the issue slots
- rf_raddr  out  NUM_PORTS*PREG_W  read-port addresses
- rf_ren  out  NUM_PORTS  read-port enables
- rrd_valid  out  NUM_SLOTS  registered: granted uop is present in the RRD stage
- rrd_br_mask  out  NUM_SLOTS*BR_W  registered branch mask, with resolved bits cleared
- rrd_rs1_port  out  NUM_SLOTS*2  port index holding rs1 (field width is clog2(NUM_PORTS))
- rrd_rs2_port  out  NUM_SLOTS*2  port index holding rs2

Behaviour:
- Need per slot: need[s] = rs1_used + rs2_used, range 0..2.
- A request is killed when (req_br_mask & brupdate_mispredict_mask) != 0. A killed request is never granted and consumes no ports.
- Allocation order (combinational, same cycle as the request):
  - Urgent slots first, in ascending index order.
  - Then non-urgent slots, in ascending index order.
- Grant rule:
  - A slot is granted iff it is valid, not killed, stall is low, and need <= free ports remaining.
  - Ports are taken lowest index first; rs1 is placed before rs2.
  - A denied slot does not block later slots.
  - need == 0 is always granted when not stalled.
- rf_ren[p] = 1 iff port p was allocated this cycle. rf_raddr[p] = the allocated index, else 0.
- Starvation counter, 3 bits per slot:
  - Cleared on grant, when the slot is not valid, or when it is killed.
  - Incremented when valid, not killed, not stalled and denied.
  - Saturates at STARVE_LIMIT.
  - Slot is urgent while its counter == STARVE_LIMIT.
  - Stall cycles hold the counter.
- Pipeline register, latency 1:
  - Grant at cycle N gives rrd_valid at N+1, with port indices and br_mask captured.
  - rrd_br_mask = captured mask & ~brupdate_resolve_mask, applied on capture and every cycle while held.
  - Held entry is invalidated when (its mask & brupdate_mispredict_mask) != 0.
  - While stall = 1: register holds except for kill and resolve updates; req_gnt = 0; rf_ren = 0.
- Simultaneous resolve and mispredict on the same bit: mispredict wins, and the entry is invalidated.
- Reset (asynchronous, any time):
  - rrd_valid = 0, rrd_br_mask = 0, port fields = 0, starvation counters = 0.
  - Combinational outputs follow their inputs; req_gnt and rf_ren are gated to 0 while reset is asserted.

Optional Feature:
- Macro: RRD_PERF_COUNTERS_EN.
- When defined:
  - Adds output perf_conflict_cycles, 32-bit, saturating. It increments on every cycle with stall = 0 where at least one valid, non-killed slot is denied.
  - Adds output perf_urgent_grants, 16-bit, saturating. It increments on every grant to an urgent slot.
  - Both counters reset to 0.
- When undefined: neither port nor the counter logic exists.

Decomposition:
- Package rrd_sched_pkg holds:
  - RT_FIX constant
  - port-index typedef
  - per-slot request struct (valid, prs1, prs2, used bits, br_mask)
  - STARVE_W = 3
- Sub-module rrd_port_alloc: purely combinational priority allocator. Inputs are need and order vectors; outputs are grants and the port mapping.
- The top level holds counters, the pipeline register and the kill logic.

Test Plan:
- 3 slots each need 2, no stall → gnt = 3'b011; ports 0,1 = slot0 rs1/rs2, ports 2,3 = slot1; rrd_valid = 3'b011 next cycle.
- Needs {2,2,1} → slot2 granted on port... none left, so gnt = 3'b011. Retry slot2 alone with need 1 → granted on port 0.
- Slot2 needs 2 and is denied 3 cycles in a row against slots 0/1 → on cycle 4 slot2 is urgent: gnt includes bit 2 and slot2 takes ports 0,1.
- req_br_mask[slot0] = 16'h0004 with mispredict = 16'h0004 → slot0 not granted; slot1 takes ports 0,1. Then a held entry with mask 0x0004 mispredicted → rrd_valid bit drops next cycle.
- Held entry mask 0x0006, resolve = 0x0002 → rrd_br_mask = 0x0004, valid kept. Same-cycle resolve and mispredict on 0x0004 → entry invalidated.
- stall = 1 for 2 cycles with requests pending → gnt = 0, rf_ren = 0, counters held; reset asserted mid-stall → rrd_valid = 0 asynchronously.
